// File: rtl/snp_width_adapter_pkg.sv
// Shared forwarder/snooper definitions: adapter FSM encoding and width-ratio helpers.
package snp_width_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } snp_state_e;

    // Address bits that select a narrow segment inside a wide word.
    function automatic int unsigned snp_n(input int unsigned sn_aw, input int unsigned mem_aw);
        return (sn_aw > mem_aw) ? (sn_aw - mem_aw) : 32'd0;
    endfunction

    // Narrow words per wide word.
    function automatic int unsigned snp_ratio(input int unsigned mem_w, input int unsigned sn_w);
        return (sn_w == 0) ? 32'd0 : (mem_w / sn_w);
    endfunction

endpackage

// File: rtl/snp_accum.sv
// Segment-merge accumulator: holds one partially assembled wide word.
module snp_accum #(
    parameter int unsigned MEM_WIDTH = 64,
    parameter int unsigned SN_WIDTH  = 32,
    parameter int unsigned SEG_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 fresh_i,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [SEG_WIDTH-1:0] seg_i,
    input  logic [SN_WIDTH-1:0]  data_i,
    output logic [MEM_WIDTH-1:0] acc_o,
    output logic [MEM_WIDTH-1:0] merged_c_o
);

    logic [MEM_WIDTH-1:0] acc_q;
    logic [MEM_WIDTH-1:0] acc_d;
    int unsigned          lsb_c;

    assign lsb_c = SN_WIDTH * 32'(seg_i);

    // Word as it looks with the incoming segment dropped in (on a zeroed base when fresh).
    always_comb begin
        merged_c_o = fresh_i ? '0 : acc_q;
        merged_c_o[lsb_c +: SN_WIDTH] = data_i;
    end

    // Clear wins over load so an emitted word never lingers.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = merged_c_o;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/snp_width_adapter.sv
// Packs narrow snooper writes into wide packet-memory words.
module snp_width_adapter
    import snp_width_adapter_pkg::*;
#(
    parameter int unsigned MEM_WIDTH      = 64,
    parameter int unsigned SN_WIDTH       = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 9,
    parameter int unsigned SN_ADDR_WIDTH  = 10
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic [SN_ADDR_WIDTH-1:0]  sn_addr_i,
    input  logic [SN_WIDTH-1:0]       sn_wr_data_i,
    input  logic                      sn_wr_en_i,
    input  logic                      sn_done_i,
    output logic                      sn_rdy_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [MEM_WIDTH-1:0]      mem_wr_data_o,
    output logic                      mem_wr_en_o,
    output logic                      mem_done_o
);

    localparam int unsigned N     = snp_n(SN_ADDR_WIDTH, MEM_ADDR_WIDTH);
    localparam int unsigned RATIO = snp_ratio(MEM_WIDTH, SN_WIDTH);

    if (N < 1 || RATIO != (32'd1 << N)) begin : g_bad_cfg
        $error("snp_width_adapter: MEM_WIDTH/SN_WIDTH must equal 2**(SN_ADDR_WIDTH-MEM_ADDR_WIDTH) with N>=1");
    end

    snp_state_e                state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] pend_q, pend_d;
    logic                      done_pend_q, done_pend_d;
    logic                      rdy_q, rdy_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_WIDTH-1:0]      mem_wr_data_q, mem_wr_data_d;
    logic                      mem_wr_en_q, mem_wr_en_d;
    logic                      mem_done_q, mem_done_d;

    logic                      acc_fresh, acc_load, acc_clear;
    logic [MEM_WIDTH-1:0]      acc_c, merged_c;
    logic [MEM_ADDR_WIDTH-1:0] word_c;
    logic [N-1:0]              seg_c;
    logic                      last_c, wr_c, dn_c;

    assign word_c = sn_addr_i[SN_ADDR_WIDTH-1:N];
    assign seg_c  = sn_addr_i[N-1:0];
    assign last_c = &seg_c;
    assign wr_c   = sn_wr_en_i & rdy_q;
    assign dn_c   = sn_done_i & rdy_q;

    snp_accum #(
        .MEM_WIDTH (MEM_WIDTH),
        .SN_WIDTH  (SN_WIDTH),
        .SEG_WIDTH (N)
    ) u_accum (
        .clk        (clk),
        .rst_i      (rst_i),
        .fresh_i    (acc_fresh),
        .load_i     (acc_load),
        .clear_i    (acc_clear),
        .seg_i      (seg_c),
        .data_i     (sn_wr_data_i),
        .acc_o      (acc_c),
        .merged_c_o (merged_c)
    );

    // Next state, accumulator control and memory-port next values.
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        done_pend_d   = done_pend_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_wr_en_d   = 1'b0;
        mem_done_d    = 1'b0;
        acc_fresh     = 1'b0;
        acc_load      = 1'b0;
        acc_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_c) begin
                    acc_fresh = 1'b1;
                    if (last_c || dn_c) begin
                        mem_wr_en_d   = 1'b1;
                        mem_done_d    = dn_c;
                        mem_addr_d    = word_c;
                        mem_wr_data_d = merged_c;
                        acc_clear     = 1'b1;
                    end else begin
                        acc_load = 1'b1;
                        pend_d   = word_c;
                        state_d  = ST_ACC;
                    end
                end else if (dn_c) begin
                    mem_done_d = 1'b1;
                end
            end
            ST_ACC: begin
                if (wr_c && word_c == pend_q) begin
                    if (last_c || dn_c) begin
                        mem_wr_en_d   = 1'b1;
                        mem_done_d    = dn_c;
                        mem_addr_d    = pend_q;
                        mem_wr_data_d = merged_c;
                        acc_clear     = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        acc_load = 1'b1;
                    end
                end else if (wr_c) begin
                    // Address conflict: flush the old partial word, restart on the new one.
                    mem_wr_en_d   = 1'b1;
                    mem_addr_d    = pend_q;
                    mem_wr_data_d = acc_c;
                    acc_fresh     = 1'b1;
                    acc_load      = 1'b1;
                    pend_d        = word_c;
                    if (last_c || dn_c) begin
                        done_pend_d = dn_c;
                        state_d     = ST_DRAIN;
                    end
                end else if (dn_c) begin
                    mem_wr_en_d   = 1'b1;
                    mem_done_d    = 1'b1;
                    mem_addr_d    = pend_q;
                    mem_wr_data_d = acc_c;
                    acc_clear     = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                mem_wr_en_d   = 1'b1;
                mem_done_d    = done_pend_q;
                mem_addr_d    = pend_q;
                mem_wr_data_d = acc_c;
                acc_clear     = 1'b1;
                done_pend_d   = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                acc_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase

        rdy_d = (state_d != ST_DRAIN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            pend_q        <= '0;
            done_pend_q   <= 1'b0;
            rdy_q         <= 1'b1;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            done_pend_q   <= done_pend_d;
            rdy_q         <= rdy_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_done_q    <= mem_done_d;
        end
    end

    assign sn_rdy_o      = rdy_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wr_data_o = mem_wr_data_q;
    assign mem_wr_en_o   = mem_wr_en_q;
    assign mem_done_o    = mem_done_q;

endmodule

// File: tb/tb_snp_width_adapter.sv
// Directed bench for snp_width_adapter at the default 32->64 bit ratio.
module tb_snp_width_adapter;

    logic        clk;
    logic        rst;
    logic [9:0]  sn_addr;
    logic [31:0] sn_wr_data;
    logic        sn_wr_en;
    logic        sn_done;
    logic        sn_rdy;
    logic [8:0]  mem_addr;
    logic [63:0] mem_wr_data;
    logic        mem_wr_en;
    logic        mem_done;

    int errors = 0;
    int checks = 0;

    snp_width_adapter dut (
        .clk           (clk),
        .rst_i         (rst),
        .sn_addr_i     (sn_addr),
        .sn_wr_data_i  (sn_wr_data),
        .sn_wr_en_i    (sn_wr_en),
        .sn_done_i     (sn_done),
        .sn_rdy_o      (sn_rdy),
        .mem_addr_o    (mem_addr),
        .mem_wr_data_o (mem_wr_data),
        .mem_wr_en_o   (mem_wr_en),
        .mem_done_o    (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic r, input logic wr, input logic [9:0] a,
                       input logic [31:0] d, input logic dn);
        rst        = r;
        sn_wr_en   = wr;
        sn_addr    = a;
        sn_wr_data = d;
        sn_done    = dn;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        sn_wr_en = 1'b0;
        sn_done  = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic en, input logic [8:0] a,
                           input logic [63:0] d, input logic dn, input logic rdy);
        chk({tag, ".wr_en"}, 64'(mem_wr_en), 64'(en));
        chk({tag, ".addr"},  64'(mem_addr),  64'(a));
        chk({tag, ".data"},  mem_wr_data,    d);
        chk({tag, ".done"},  64'(mem_done),  64'(dn));
        chk({tag, ".rdy"},   64'(sn_rdy),    64'(rdy));
    endtask

    initial begin
        rst = 1'b1; sn_addr = '0; sn_wr_data = '0; sn_wr_en = 1'b0; sn_done = 1'b0;
        cyc(1'b1, 1'b0, 10'h000, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 10'h000, 32'h0, 1'b0);
        chk_all("reset", 1'b0, 9'd0, 64'h0, 1'b0, 1'b1);

        // Two halves of word 0
        cyc(1'b0, 1'b1, 10'h000, 32'hAAAA_AAAA, 1'b0);
        chk("w0_lo.wr_en", 64'(mem_wr_en), 64'd0);
        cyc(1'b0, 1'b1, 10'h001, 32'hBBBB_BBBB, 1'b0);
        chk_all("w0_full", 1'b1, 9'd0, 64'hBBBB_BBBB_AAAA_AAAA, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        chk_all("w0_hold", 1'b0, 9'd0, 64'hBBBB_BBBB_AAAA_AAAA, 1'b0, 1'b1);

        // Partial word flushed by done
        cyc(1'b0, 1'b1, 10'h004, 32'h1111_1111, 1'b0);
        chk("part.wr_en", 64'(mem_wr_en), 64'd0);
        cyc(1'b0, 1'b0, 10'h000, 32'h0, 1'b1);
        chk_all("part_done", 1'b1, 9'd2, 64'h0000_0000_1111_1111, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        chk("part_after.done", 64'(mem_done), 64'd0);

        // Address conflict deferring a full word; the write during DRAIN is ignored
        cyc(1'b0, 1'b1, 10'h006, 32'h0000_0001, 1'b0);
        chk("conf_a.wr_en", 64'(mem_wr_en), 64'd0);
        cyc(1'b0, 1'b1, 10'h00B, 32'h0000_0002, 1'b0);
        chk_all("conf_old", 1'b1, 9'd3, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 10'h000, 32'hFFFF_FFFF, 1'b0);
        chk_all("conf_new", 1'b1, 9'd5, 64'h0000_0002_0000_0000, 1'b0, 1'b1);

        // Done with nothing pending (also proves the DRAIN-cycle write was dropped)
        cyc(1'b0, 1'b0, 10'h000, 32'h0, 1'b1);
        chk_all("done_only", 1'b0, 9'd5, 64'h0000_0002_0000_0000, 1'b1, 1'b1);

        // Rewrite of same segment: last write wins
        cyc(1'b0, 1'b1, 10'h010, 32'h0000_0005, 1'b0);
        cyc(1'b0, 1'b1, 10'h010, 32'h0000_0006, 1'b0);
        chk("rewr.wr_en", 64'(mem_wr_en), 64'd0);
        cyc(1'b0, 1'b1, 10'h011, 32'h0000_0007, 1'b0);
        chk_all("rewr", 1'b1, 9'd8, 64'h0000_0007_0000_0006, 1'b0, 1'b1);

        // Conflict plus done in the same cycle
        cyc(1'b0, 1'b1, 10'h020, 32'h0000_0009, 1'b0);
        cyc(1'b0, 1'b1, 10'h031, 32'h0000_000C, 1'b1);
        chk_all("cd_old", 1'b1, 9'h010, 64'h0000_0000_0000_0009, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        chk_all("cd_new", 1'b1, 9'h018, 64'h0000_000C_0000_0000, 1'b1, 1'b1);

        // Low-half write with done in IDLE
        cyc(1'b0, 1'b1, 10'h040, 32'h0000_000D, 1'b1);
        chk_all("wr_done", 1'b1, 9'h020, 64'h0000_0000_0000_000D, 1'b1, 1'b1);

        // Reset mid-packet dominates a same-cycle write
        cyc(1'b0, 1'b1, 10'h000, 32'hAAAA_AAAA, 1'b0);
        cyc(1'b1, 1'b1, 10'h001, 32'hCCCC_CCCC, 1'b1);
        chk_all("rst_mid", 1'b0, 9'd0, 64'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 10'h000, 32'h0, 1'b0);
        chk_all("rst_idle", 1'b0, 9'd0, 64'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 10'h001, 32'hBBBB_BBBB, 1'b0);
        chk_all("rst_upper", 1'b1, 9'd0, 64'hBBBB_BBBB_0000_0000, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
